// File: rtl/debug_cmd_dispatch.sv
// Virtual-JTAG capture: synchronises update strobes into clk, queues {ir, sr}
// commands in a FIFO and decodes each dispatched command into one-cycle pulses.
module debug_cmd_dispatch #(
  parameter int unsigned DATA_W      = 38,
  parameter int unsigned IR_W        = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACT_BIT     = 37,
  localparam int unsigned NUM_CODES  = 2**IR_W,
  localparam int unsigned AW         = $clog2(FIFO_DEPTH),
  localparam int unsigned PW         = AW + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 vs_uir,
  input  logic                 vs_udr,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [DATA_W-1:0]    sr,
  input  logic                 cmd_ready,
  input  logic                 overflow_clr,
  output logic                 cmd_valid,
  output logic [IR_W-1:0]      cmd_ir,
  output logic [DATA_W-1:0]    cmd_data,
  output logic [DATA_W-1:0]    jdo,
  output logic [NUM_CODES-1:0] take_action,
  output logic [NUM_CODES-1:0] take_no_action,
  output logic [IR_W-1:0]      ir_latched,
  output logic [PW-1:0]        fifo_level,
  output logic                 overflow
);

  localparam int unsigned EW = IR_W + DATA_W;

  logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
  logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
  logic                   uir_prev_q, uir_prev_d;
  logic                   udr_prev_q, udr_prev_d;
  logic                   uir_p, udr_p;

  logic [IR_W-1:0]        ir_q, ir_d;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [EW-1:0]          mem_d [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic                   overflow_q, overflow_d;

  logic [DATA_W-1:0]      jdo_q, jdo_d;
  logic [NUM_CODES-1:0]   act_q, act_d;
  logic [NUM_CODES-1:0]   noact_q, noact_d;

  logic [PW-1:0]          level;
  logic                   full, empty, pop, push_ok, drop;
  logic [EW-1:0]          head;

  assign uir_p = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;
  assign udr_p = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == PW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign pop     = ~empty & cmd_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign push_ok = udr_p & (~full | pop);
  assign drop    = udr_p & full & ~pop;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    uir_prev_d = uir_sync_q[SYNC_STAGES-1];
    udr_prev_d = udr_sync_q[SYNC_STAGES-1];
    ir_d       = uir_p ? ir_in : ir_q;
  end

  // The push reads ir_q, so a coincident uir_p only affects later commands.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = {ir_q, sr};
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    jdo_d   = jdo_q;
    act_d   = '0;
    noact_d = '0;
    if (pop) begin
      jdo_d = head[DATA_W-1:0];
      if (head[ACT_BIT]) begin
        act_d[head[EW-1 -: IR_W]] = 1'b1;
      end else begin
        noact_d[head[EW-1 -: IR_W]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      uir_sync_q <= '0;
      udr_sync_q <= '0;
      uir_prev_q <= 1'b0;
      udr_prev_q <= 1'b0;
      ir_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      jdo_q      <= '0;
      act_q      <= '0;
      noact_q    <= '0;
    end else begin
      uir_sync_q <= uir_sync_d;
      udr_sync_q <= udr_sync_d;
      uir_prev_q <= uir_prev_d;
      udr_prev_q <= udr_prev_d;
      ir_q       <= ir_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      jdo_q      <= jdo_d;
      act_q      <= act_d;
      noact_q    <= noact_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign cmd_valid      = ~empty;
  assign cmd_ir         = head[EW-1 -: IR_W];
  assign cmd_data       = head[DATA_W-1:0];
  assign jdo            = jdo_q;
  assign take_action    = act_q;
  assign take_no_action = noact_q;
  assign ir_latched     = ir_q;
  assign fifo_level     = level;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_debug_cmd_dispatch.sv
// Scoreboard bench for debug_cmd_dispatch: directed corner cases plus random
// bursts, checked against a queue-based command model.
module tb_debug_cmd_dispatch;

  localparam int unsigned DATA_W      = 38;
  localparam int unsigned IR_W        = 2;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned ACT_BIT     = 37;
  localparam int unsigned NUM_CODES   = 2**IR_W;
  localparam int unsigned PW          = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW          = IR_W + DATA_W;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 vs_uir = 1'b0;
  logic                 vs_udr = 1'b0;
  logic [IR_W-1:0]      ir_in = '0;
  logic [DATA_W-1:0]    sr = '0;
  logic                 cmd_ready = 1'b0;
  logic                 overflow_clr = 1'b0;
  logic                 cmd_valid;
  logic [IR_W-1:0]      cmd_ir;
  logic [DATA_W-1:0]    cmd_data;
  logic [DATA_W-1:0]    jdo;
  logic [NUM_CODES-1:0] take_action;
  logic [NUM_CODES-1:0] take_no_action;
  logic [IR_W-1:0]      ir_latched;
  logic [PW-1:0]        fifo_level;
  logic                 overflow;

  debug_cmd_dispatch #(
    .DATA_W(DATA_W), .IR_W(IR_W), .SYNC_STAGES(SYNC_STAGES),
    .FIFO_DEPTH(FIFO_DEPTH), .ACT_BIT(ACT_BIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .overflow_clr(overflow_clr),
    .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .cmd_data(cmd_data), .jdo(jdo),
    .take_action(take_action), .take_no_action(take_no_action),
    .ir_latched(ir_latched), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [IR_W-1:0] model_ir = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compares the head on every accepted pop, then the dispatch
  // pulses and jdo one cycle later.
  logic          pend = 1'b0;
  logic [EW-1:0] pend_e;
  always @(negedge clk) begin
    logic [NUM_CODES-1:0] e_act, e_no;
    logic [EW-1:0]        e;
    if (!reset_n) begin
      pend = 1'b0;
    end else begin
      e_act = '0;
      e_no  = '0;
      if (pend) begin
        if (pend_e[ACT_BIT]) e_act[pend_e[EW-1 -: IR_W]] = 1'b1;
        else                 e_no[pend_e[EW-1 -: IR_W]]  = 1'b1;
        chk("jdo", 64'(jdo), 64'(pend_e[DATA_W-1:0]));
      end
      chk("take_action", 64'(take_action), 64'(e_act));
      chk("take_no_action", 64'(take_no_action), 64'(e_no));
      pend = 1'b0;
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 64'(cmd_data), 64'(0));
          if (cmd_data == '0) begin
            errors++;
            $display("FAIL unexpected_pop actual=pop required=no_pop");
          end
        end else begin
          e = exp_q.pop_front();
          chk("head", 64'({cmd_ir, cmd_data}), 64'(e));
          pend   = 1'b1;
          pend_e = e;
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int unsigned n);
    reset_n = 1'b0;
    exp_q.delete();
    model_ir = '0;
    tick(n);
    reset_n = 1'b1;
  endtask

  // Full strobe pulse; keep=0 marks a command the model expects to be dropped.
  task automatic strobe(input bit u, input bit d, input bit rnd, input bit keep);
    if (d && keep) exp_q.push_back({model_ir, sr});
    if (u) model_ir = ir_in;
    vs_uir = u;
    vs_udr = d;
    repeat (SYNC_STAGES + 3) begin
      tick(1);
      if (rnd) cmd_ready = 1'($urandom_range(0, 1));
    end
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    repeat (SYNC_STAGES + 2) begin
      tick(1);
      if (rnd) cmd_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    cmd_ready = 1'b1;
    while (cmd_valid && n < 40) begin
      tick(1);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", 64'(cmd_valid), 64'(0));
    chk("model_empty", 64'(exp_q.size()), 64'(0));
    #1;
    cmd_ready = 1'b0;
  endtask

  task automatic rand_sr();
    logic [63:0] r;
    r  = {$urandom(), $urandom()};
    sr = r[DATA_W-1:0];
  endtask

  initial begin
    logic [63:0] r;
    #1;
    // Reset and idle
    do_reset(3);
    chk("rst_valid", 64'(cmd_valid), 64'(0));
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_jdo", 64'(jdo), 64'(0));
    chk("rst_act", 64'(take_action), 64'(0));
    chk("rst_noact", 64'(take_no_action), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_ir", 64'(ir_latched), 64'(0));
    tick(10);
    chk("idle_valid", 64'(cmd_valid), 64'(0));

    // IR then DR with exact latencies
    ir_in = 2'd2;
    vs_uir = 1'b1;
    model_ir = 2'd2;
    tick(2);
    chk("ir_before", 64'(ir_latched), 64'(0));
    tick(1);
    chk("ir_after", 64'(ir_latched), 64'(2));
    vs_uir = 1'b0;
    tick(4);
    sr = 38'h20_0000_1234;
    exp_q.push_back({model_ir, sr});
    cmd_ready = 1'b1;
    vs_udr = 1'b1;
    tick(2);
    chk("no_bypass", 64'(cmd_valid), 64'(0));
    tick(1);
    chk("valid_rise", 64'(cmd_valid), 64'(1));
    tick(1);
    chk("act_pulse", 64'(take_action), 64'(4'b0100));
    chk("act_jdo", 64'(jdo), 64'(38'h20_0000_1234));
    tick(1);
    chk("act_one_cycle", 64'(take_action), 64'(0));
    chk("jdo_held", 64'(jdo), 64'(38'h20_0000_1234));
    vs_udr = 1'b0;
    tick(4);

    // No-action path
    ir_in = 2'd1;
    strobe(1, 0, 0, 1);
    sr = 38'h0F_0000_5678;
    strobe(0, 1, 0, 1);
    tick(2);
    chk("noact_jdo", 64'(jdo), 64'(38'h0F_0000_5678));
    chk("noact_level", 64'(fifo_level), 64'(0));

    // Fill, drop with coincident clear, then clear
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_sr();
      strobe(0, 1, 0, 1);
    end
    chk("full_level", 64'(fifo_level), 64'(4));
    chk("full_no_ovf", 64'(overflow), 64'(0));
    rand_sr();
    vs_udr = 1'b1;
    tick(2);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    chk("drop_wins", 64'(overflow), 64'(1));
    chk("drop_level", 64'(fifo_level), 64'(4));
    vs_udr = 1'b0;
    tick(4);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'(0));
    drain();

    // Full with simultaneous push/pop
    for (int i = 0; i < 4; i++) begin
      rand_sr();
      strobe(0, 1, 0, 1);
    end
    rand_sr();
    exp_q.push_back({model_ir, sr});
    vs_udr = 1'b1;
    tick(2);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    chk("pp_level", 64'(fifo_level), 64'(4));
    chk("pp_ovf", 64'(overflow), 64'(0));
    vs_udr = 1'b0;
    tick(4);
    drain();

    // vs_udr held high through reset
    sr = 38'h3A_BCDE_F012;
    vs_udr = 1'b1;
    do_reset(3);
    exp_q.push_back({model_ir, sr});
    tick(8);
    vs_udr = 1'b0;
    tick(6);
    chk("held_one_push", 64'(fifo_level), 64'(1));
    drain();

    // Simultaneous uir and udr: entry carries the old IR
    ir_in = 2'd3;
    strobe(1, 0, 0, 1);
    ir_in = 2'd1;
    rand_sr();
    strobe(1, 1, 0, 1);
    chk("simul_ir", 64'(ir_latched), 64'(1));
    drain();

    // Mid-stream reset
    for (int i = 0; i < 2; i++) begin
      rand_sr();
      strobe(0, 1, 0, 1);
    end
    cmd_ready = 1'b1;
    do_reset(2);
    chk("mid_valid", 64'(cmd_valid), 64'(0));
    chk("mid_level", 64'(fifo_level), 64'(0));
    chk("mid_jdo", 64'(jdo), 64'(0));
    tick(6);
    cmd_ready = 1'b0;

    // Random bursts that never exceed the FIFO depth
    for (int it = 0; it < 40; it++) begin
      r = 64'($urandom_range(0, 3));
      if (r == 0) begin
        ir_in = IR_W'($urandom_range(0, NUM_CODES - 1));
        strobe(1, 0, 1, 1);
      end else begin
        for (int b = 0; b < int'($urandom_range(1, FIFO_DEPTH)); b++) begin
          rand_sr();
          if ($urandom_range(0, 4) == 0) begin
            ir_in = IR_W'($urandom_range(0, NUM_CODES - 1));
            strobe(1, 1, 1, 1);
          end else begin
            strobe(0, 1, 1, 1);
          end
        end
        drain();
        chk("rnd_ovf", 64'(overflow), 64'(0));
      end
    end
    chk("rnd_ir", 64'(ir_latched), 64'(model_ir));

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
